// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter: sequences the processor-side bus of one spart.
// Programs the baud divisor after reset and on every br_cfg change, then
// shares the bus between two byte clients: received bytes are drained first,
// transmit writes are granted round-robin when both clients are waiting.
module spart_bus_arbiter #(
  parameter logic [15:0] DIV_4800  = 16'd650,
  parameter logic [15:0] DIV_9600  = 16'd325,
  parameter logic [15:0] DIV_19200 = 16'd162,
  parameter logic [15:0] DIV_38400 = 16'd80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       tx_valid0,
  input  logic [7:0] tx_data0,
  output logic       tx_ack0,
  input  logic       tx_valid1,
  input  logic [7:0] tx_data1,
  output logic       tx_ack1,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_id,
  output logic       cfg_done,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        rst_q;
  logic [1:0]  br_cfg_q;
  logic        cfg_change;
  logic        cfg_done_reg, cfg_done_next;
  logic        rr_reg, rr_next;
  logic        grant_reg, grant_next;
  logic        last_grant_reg;
  logic [1:0]  tx_ack_reg, tx_ack_next;
  logic        rx_valid_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_id_reg;
  logic [15:0] div;
  logic        bus_cs, bus_rw;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_dout;

  // Reset takes effect at once (bus released) but is let go on a clock edge,
  // so the first configuration write is a full, clean bus cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= 1'b0;
    else      rst_q <= 1'b1;
  end

  // Baud select snapshot: follows br_cfg while in reset, then only when IDLE accepts a change.
  always_ff @(posedge clk) begin
    if (!rst_q || cfg_change) br_cfg_q <= br_cfg;
  end

  // Divisor for the latched baud select.
  always_comb begin
    case (br_cfg_q)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  // Next-state, grant and bus-cycle decode; bus signals depend only on the current state.
  always_comb begin
    state_next    = state_reg;
    cfg_done_next = cfg_done_reg;
    rr_next       = rr_reg;
    grant_next    = grant_reg;
    cfg_change    = 1'b0;
    bus_cs        = 1'b0;
    bus_rw        = 1'b1;
    bus_addr      = 2'b00;
    bus_dout      = 8'h00;
    case (state_reg)
      CFG_LO: begin
        bus_cs     = 1'b1;
        bus_rw     = 1'b0;
        bus_addr   = 2'b10;
        bus_dout   = div[7:0];
        state_next = CFG_HI;
      end
      CFG_HI: begin
        bus_cs        = 1'b1;
        bus_rw        = 1'b0;
        bus_addr      = 2'b11;
        bus_dout      = div[15:8];
        cfg_done_next = 1'b1;
        state_next    = WAIT;
      end
      IDLE: begin
        if (br_cfg != br_cfg_q) begin
          cfg_change    = 1'b1;
          cfg_done_next = 1'b0;
          state_next    = CFG_LO;
        end else if (rda) begin
          // Draining RX first keeps a TX burst from overrunning the receiver.
          state_next = RD;
        end else if (tbr && cfg_done_reg && (tx_valid0 || tx_valid1)) begin
          state_next = WR;
          if (tx_valid0 && tx_valid1) begin
            grant_next = rr_reg;
            rr_next    = ~rr_reg;
          end else begin
            grant_next = tx_valid1;
          end
        end
      end
      RD: begin
        bus_cs     = 1'b1;
        bus_rw     = 1'b1;
        bus_addr   = 2'b00;
        state_next = WAIT;
      end
      WR: begin
        bus_cs     = 1'b1;
        bus_rw     = 1'b0;
        bus_addr   = 2'b00;
        bus_dout   = grant_reg ? tx_data1 : tx_data0;
        state_next = WAIT;
      end
      WAIT: begin
        // One dead cycle lets the spart refresh rda/tbr before the next decision.
        state_next = IDLE;
      end
      default: begin
        state_next = CFG_LO;
      end
    endcase
  end

  // Acknowledge the granted client in the cycle after its write.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ack
    assign tx_ack_next[gi] = (state_reg == WR) && (grant_reg == 1'(gi));
  end

  // State, arbitration and client-side result registers.
  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      state_reg      <= CFG_LO;
      cfg_done_reg   <= 1'b0;
      rr_reg         <= 1'b0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      tx_ack_reg     <= 2'b00;
      rx_valid_reg   <= 1'b0;
      rx_data_reg    <= 8'h00;
      rx_id_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cfg_done_reg <= cfg_done_next;
      rr_reg       <= rr_next;
      grant_reg    <= grant_next;
      tx_ack_reg   <= tx_ack_next;
      rx_valid_reg <= (state_reg == RD);
      if (state_reg == WR) last_grant_reg <= grant_reg;
      if (state_reg == RD) begin
        rx_data_reg <= databus;
        rx_id_reg   <= last_grant_reg;
      end
    end
  end

  // Bus outputs are forced idle while reset is held so nothing is driven mid-reset.
  assign iocs     = bus_cs & rst_q;
  assign iorw     = bus_rw | ~rst_q;
  assign ioaddr   = rst_q ? bus_addr : 2'b00;
  assign databus  = (iocs && !iorw) ? bus_dout : 8'bz;

  assign tx_ack0  = tx_ack_reg[0];
  assign tx_ack1  = tx_ack_reg[1];
  assign rx_valid = rx_valid_reg;
  assign rx_data  = rx_data_reg;
  assign rx_id    = rx_id_reg;
  assign cfg_done = cfg_done_reg;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter. Inputs change and outputs are
// sampled on the falling edge; a minimal spart model drives databus on reads.
module tb_spart_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       tx_valid0, tx_valid1;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_ack0, tx_ack1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_id;
  logic       cfg_done;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic [7:0] spart_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // spart side of the bus: returns its receive byte on any read cycle.
  assign databus = (iocs && iorw) ? spart_rd : 8'bz;

  spart_bus_arbiter dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg),
    .tx_valid0(tx_valid0), .tx_data0(tx_data0), .tx_ack0(tx_ack0),
    .tx_valid1(tx_valid1), .tx_data1(tx_data1), .tx_ack1(tx_ack1),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id), .cfg_done(cfg_done),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; spart_rd = 8'h00;
    tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_data0 = 8'h00; tx_data1 = 8'h00;
    repeat (3) tick();
    checks++; if ({iocs, iorw, ioaddr} !== 4'b0100) begin errors++; $display("FAIL reset_bus: cs/rw/addr got %b want 0100", {iocs, iorw, ioaddr}); end
    checks++; if ({cfg_done, tx_ack0, tx_ack1, rx_valid, rx_id} !== 5'b00000) begin errors++; $display("FAIL reset_flags: done/ack0/ack1/rxv/id got %b want 00000", {cfg_done, tx_ack0, tx_ack1, rx_valid, rx_id}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    rst = 1'b1;
    tick(); // CFG_LO: 325 = 0x0145
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h45) begin errors++; $display("FAIL cfg_lo: cs/rw/addr %b data %h want 1010 45", {iocs, iorw, ioaddr}, databus); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_lo_done: got %b want 0", cfg_done); end
    tick(); // CFG_HI
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h01) begin errors++; $display("FAIL cfg_hi: cs/rw/addr %b data %h want 1011 01", {iocs, iorw, ioaddr}, databus); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_hi_done: got %b want 0", cfg_done); end
    tick(); // WAIT, 3rd posedge after release
    checks++; if ({cfg_done, iocs} !== 2'b10) begin errors++; $display("FAIL cfg_done_rise: done/cs got %b want 10", {cfg_done, iocs}); end
    tick(); // IDLE
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL idle_cs: got %b want 0", iocs); end
  endtask

  task automatic test_tx_loopback();
    tbr = 1'b1; tx_valid0 = 1'b1; tx_data0 = 8'h48;
    tick(); // WR
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1000 || databus !== 8'h48) begin errors++; $display("FAIL tx_wr: cs/rw/addr %b data %h want 1000 48", {iocs, iorw, ioaddr}, databus); end
    checks++; if ({tx_ack0, tx_ack1} !== 2'b00) begin errors++; $display("FAIL tx_ack_early: got %b want 00", {tx_ack0, tx_ack1}); end
    tick(); // WAIT
    checks++; if ({tx_ack0, tx_ack1, iocs} !== 3'b100) begin errors++; $display("FAIL tx_ack: ack0/ack1/cs got %b want 100", {tx_ack0, tx_ack1, iocs}); end
    tx_valid0 = 1'b0; tbr = 1'b0;
    tick(); // IDLE
    checks++; if ({tx_ack0, tx_ack1} !== 2'b00) begin errors++; $display("FAIL tx_ack_pulse: got %b want 00", {tx_ack0, tx_ack1}); end
    spart_rd = 8'h48; rda = 1'b1;
    tick(); // RD
    checks++; if ({iocs, iorw, ioaddr, rx_valid} !== 5'b11000) begin errors++; $display("FAIL rd_cycle: cs/rw/addr/rxv got %b want 11000", {iocs, iorw, ioaddr, rx_valid}); end
    rda = 1'b0;
    tick(); // WAIT
    checks++; if ({rx_valid, rx_data, rx_id} !== {1'b1, 8'h48, 1'b0}) begin errors++; $display("FAIL loopback_rx: rxv %b data %h id %b want 1 48 0", rx_valid, rx_data, rx_id); end
    tick(); // IDLE
    checks++; if ({rx_valid, rx_data} !== {1'b0, 8'h48}) begin errors++; $display("FAIL rx_hold: rxv %b data %h want 0 48", rx_valid, rx_data); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int last_cyc = 0;
    tx_data0 = 8'hA0; tx_data1 = 8'hB1; tx_valid0 = 1'b1; tx_valid1 = 1'b1; tbr = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tick();
      if (iocs && !iorw) begin
        checks++; if (databus !== (n[0] ? 8'hB1 : 8'hA0)) begin errors++; $display("FAIL rr_wr_data %0d: got %h want %h", n, databus, n[0] ? 8'hB1 : 8'hA0); end
      end
      if (tx_ack0 || tx_ack1) begin
        checks++; if ({tx_ack1, tx_ack0} !== (n[0] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_order %0d: ack1/ack0 got %b want %b", n, {tx_ack1, tx_ack0}, n[0] ? 2'b10 : 2'b01); end
        if (n > 0) begin
          checks++; if (cyc - last_cyc < 2) begin errors++; $display("FAIL rr_spacing %0d: gap %0d want >= 2", n, cyc - last_cyc); end
        end
        last_cyc = cyc;
        n++;
        if (n == 4) begin tx_valid0 = 1'b0; tx_valid1 = 1'b0; tbr = 1'b0; end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d acks want 4", n); end
  endtask

  task automatic test_rx_priority();
    tick(); // IDLE
    rda = 1'b1; spart_rd = 8'h5A; tx_valid1 = 1'b1; tx_data1 = 8'h31; tbr = 1'b1;
    tick(); // RD wins over WR
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL prio_rd: cs/rw/addr got %b want 1100", {iocs, iorw, ioaddr}); end
    rda = 1'b0;
    tick(); // WAIT
    checks++; if ({rx_valid, rx_data, rx_id} !== {1'b1, 8'h5A, 1'b1}) begin errors++; $display("FAIL prio_rx: rxv %b data %h id %b want 1 5a 1", rx_valid, rx_data, rx_id); end
    tick(); // IDLE
    checks++; if ({iocs, tx_ack1} !== 2'b00) begin errors++; $display("FAIL prio_idle: cs/ack1 got %b want 00", {iocs, tx_ack1}); end
    tick(); // WR client 1
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1000 || databus !== 8'h31) begin errors++; $display("FAIL prio_wr: cs/rw/addr %b data %h want 1000 31", {iocs, iorw, ioaddr}, databus); end
    tick(); // WAIT
    checks++; if ({tx_ack0, tx_ack1} !== 2'b01) begin errors++; $display("FAIL prio_ack: ack0/ack1 got %b want 01", {tx_ack0, tx_ack1}); end
    tx_valid1 = 1'b0; tbr = 1'b0;
  endtask

  task automatic test_reconfig();
    tick(); // IDLE
    tx_valid0 = 1'b1; tx_data0 = 8'h77; tbr = 1'b1;
    tick(); // WR
    checks++; if ({iocs, iorw} !== 2'b10 || databus !== 8'h77) begin errors++; $display("FAIL recfg_wr: cs/rw %b data %h want 10 77", {iocs, iorw}, databus); end
    br_cfg = 2'b11; tx_valid1 = 1'b1; tx_data1 = 8'h99;
    tick(); // WAIT: in-flight write still acknowledged
    checks++; if ({tx_ack0, tx_ack1} !== 2'b10) begin errors++; $display("FAIL recfg_ack: ack0/ack1 got %b want 10", {tx_ack0, tx_ack1}); end
    tx_valid0 = 1'b0;
    tick(); // IDLE
    checks++; if ({cfg_done, iocs} !== 2'b10) begin errors++; $display("FAIL recfg_idle: done/cs got %b want 10", {cfg_done, iocs}); end
    tick(); // CFG_LO: 80 = 0x0050
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'h50) begin errors++; $display("FAIL recfg_lo: cs/rw/addr %b data %h want 1010 50", {iocs, iorw, ioaddr}, databus); end
    checks++; if ({cfg_done, tx_ack1} !== 2'b00) begin errors++; $display("FAIL recfg_lo_done: done/ack1 got %b want 00", {cfg_done, tx_ack1}); end
    tick(); // CFG_HI
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h00) begin errors++; $display("FAIL recfg_hi: cs/rw/addr %b data %h want 1011 00", {iocs, iorw, ioaddr}, databus); end
    checks++; if ({cfg_done, tx_ack1} !== 2'b00) begin errors++; $display("FAIL recfg_hi_done: done/ack1 got %b want 00", {cfg_done, tx_ack1}); end
    tick(); // WAIT
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL recfg_done: got %b want 1", cfg_done); end
    tick(); // IDLE
    tick(); // WR of the held client 1 request
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1000 || databus !== 8'h99) begin errors++; $display("FAIL recfg_pending_wr: cs/rw/addr %b data %h want 1000 99", {iocs, iorw, ioaddr}, databus); end
    tick(); // WAIT
    checks++; if ({tx_ack0, tx_ack1} !== 2'b01) begin errors++; $display("FAIL recfg_pending_ack: ack0/ack1 got %b want 01", {tx_ack0, tx_ack1}); end
    tx_valid1 = 1'b0; tbr = 1'b0;
  endtask

  task automatic test_reset_mid_rd();
    tick(); // IDLE
    rda = 1'b1; spart_rd = 8'hC3;
    tick(); // RD
    checks++; if ({iocs, iorw} !== 2'b11) begin errors++; $display("FAIL abort_rd_start: cs/rw got %b want 11", {iocs, iorw}); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({iocs, iorw, ioaddr, rx_valid} !== 5'b01000) begin errors++; $display("FAIL abort_release: cs/rw/addr/rxv got %b want 01000", {iocs, iorw, ioaddr, rx_valid}); end
    rda = 1'b0; br_cfg = 2'b10;
    tick();
    checks++; if ({rx_valid, cfg_done, iocs} !== 3'b000 || rx_data !== 8'h00) begin errors++; $display("FAIL abort_no_rx: rxv/done/cs %b data %h want 000 00", {rx_valid, cfg_done, iocs}, rx_data); end
    tick();
    rst = 1'b1;
    tick(); // CFG_LO: 162 = 0x00A2
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010 || databus !== 8'hA2) begin errors++; $display("FAIL abort_cfg_lo: cs/rw/addr %b data %h want 1010 a2", {iocs, iorw, ioaddr}, databus); end
    tick(); // CFG_HI
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1011 || databus !== 8'h00) begin errors++; $display("FAIL abort_cfg_hi: cs/rw/addr %b data %h want 1011 00", {iocs, iorw, ioaddr}, databus); end
    tick(); // WAIT
    checks++; if ({cfg_done, rx_valid} !== 2'b10) begin errors++; $display("FAIL abort_cfg_done: done/rxv got %b want 10", {cfg_done, rx_valid}); end
  endtask

  initial begin
    test_reset();
    test_tx_loopback();
    test_round_robin();
    test_rx_priority();
    test_reconfig();
    test_reset_mid_rd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
